// File: rtl/sd_pkg.sv
// sd_pkg: shared state/command/error types and SPI-mode command framing for sd_init_ctrl.
package sd_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_POWERUP, S_SEND, S_WAIT, S_TAIL, S_CHECK, S_DESEL, S_DONE, S_FAIL
  } state_e;
  typedef enum logic [2:0] {C_CMD0, C_CMD8, C_CMD55, C_ACMD41, C_CMD58} cmd_e;
  typedef enum logic [2:0] {
    E_NONE = 3'd0, E_CMD0 = 3'd1, E_CMD8 = 3'd2, E_CMD55 = 3'd3,
    E_ACMD41 = 3'd4, E_CMD58 = 3'd5, E_NCR = 3'd6
  } err_e;
  localparam logic [5:0] IDX_CMD0 = 6'd0;
  localparam logic [5:0] IDX_CMD8 = 6'd8;
  localparam logic [5:0] IDX_CMD55 = 6'd55;
  localparam logic [5:0] IDX_ACMD41 = 6'd41;
  localparam logic [5:0] IDX_CMD58 = 6'd58;
  localparam logic [31:0] ARG_CMD8 = 32'h0000_01AA;
  localparam logic [31:0] ARG_ACMD41 = 32'h4000_0000;
  localparam logic [7:0] CRC_CMD0 = 8'h95;
  localparam logic [7:0] CRC_CMD8 = 8'h87;
  localparam logic [7:0] CRC_NONE = 8'hFF;
  // 6-byte frame, first byte on the wire in bits [47:40]
  function automatic logic [47:0] cmd_frame(cmd_e c);
    logic [5:0] idx;
    logic [31:0] arg;
    logic [7:0] crc;
    idx = c == C_CMD0 ? IDX_CMD0 : c == C_CMD8 ? IDX_CMD8 : c == C_CMD55 ? IDX_CMD55 :
          c == C_ACMD41 ? IDX_ACMD41 : IDX_CMD58;
    arg = c == C_CMD8 ? ARG_CMD8 : c == C_ACMD41 ? ARG_ACMD41 : 32'h0;
    crc = c == C_CMD0 ? CRC_CMD0 : c == C_CMD8 ? CRC_CMD8 : CRC_NONE;
    return {2'b01, idx, arg, crc};
  endfunction
endpackage

// File: rtl/sd_init_ctrl_frame.sv
// sd_init_ctrl_frame: selects one byte of the current command frame.
module sd_init_ctrl_frame
  import sd_pkg::*;
(
  input  cmd_e       cmd_i,
  input  logic [2:0] sel_i,
  output logic [7:0] tx_o
);
  logic [47:0] f;
  assign f = cmd_frame(cmd_i);
  always_comb
    tx_o = sel_i == 3'd0 ? f[47:40] : sel_i == 3'd1 ? f[39:32] : sel_i == 3'd2 ? f[31:24] :
           sel_i == 3'd3 ? f[23:16] : sel_i == 3'd4 ? f[15:8] : f[7:0];
endmodule

// File: rtl/sd_init_ctrl.sv
// sd_init_ctrl: SD-card SPI-mode init sequencer (CMD0, CMD8, CMD55/ACMD41 loop, CMD58).
module sd_init_ctrl
  import sd_pkg::*;
#(
  parameter int POWERUP_BYTES  = 10,
  parameter int NCR_MAX        = 8,
  parameter int ACMD41_RETRIES = 1000
) (
  input  logic       clk,
  input  logic       res,
  input  logic       start,
  output logic       spi_req,
  output logic [7:0] spi_tx,
  input  logic       spi_done,
  input  logic [7:0] spi_rx,
  output logic       sd_cs,
  output logic       busy,
  output logic       init_ok,
  output logic       init_err,
  output logic [2:0] err_code,
  output logic [7:0] r1,
  output logic       ccs
);
  localparam logic [3:0] PU_LAST = 4'(POWERUP_BYTES - 1);
  localparam logic [3:0] NCR_LAST = 4'(NCR_MAX - 1);
  localparam logic [15:0] RETRY_LAST = 16'(ACMD41_RETRIES - 1);
  state_e state_q, state_d, dst_q, dst_d;
  cmd_e cmd_q, cmd_d;
  err_e err_q, err_d;
  logic pend_q, pend_d, ccs_q, ccs_d, xfer, xs;
  logic [3:0] cnt_q, cnt_d, poll_q, poll_d;
  logic [15:0] retry_q, retry_d;
  logic [31:0] tail_q, tail_d;
  logic [7:0] r1_q, r1_d, frame_tx;
  sd_init_ctrl_frame u_frame (.cmd_i(cmd_q), .sel_i(cnt_q[2:0]), .tx_o(frame_tx));
  // a done only counts when a byte is actually outstanding
  assign xfer = pend_q & spi_done;
  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= S_IDLE;
      dst_q   <= S_IDLE;
      cmd_q   <= C_CMD0;
      err_q   <= E_NONE;
      pend_q  <= 1'b0;
      ccs_q   <= 1'b0;
      cnt_q   <= '0;
      poll_q  <= '0;
      retry_q <= '0;
      tail_q  <= '0;
      r1_q    <= 8'hFF;
    end else begin
      state_q <= state_d;
      dst_q   <= dst_d;
      cmd_q   <= cmd_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
      ccs_q   <= ccs_d;
      cnt_q   <= cnt_d;
      poll_q  <= poll_d;
      retry_q <= retry_d;
      tail_q  <= tail_d;
      r1_q    <= r1_d;
    end
  end
  always_comb begin
    state_d = state_q;
    dst_d   = dst_q;
    cmd_d   = cmd_q;
    err_d   = err_q;
    ccs_d   = ccs_q;
    cnt_d   = cnt_q;
    poll_d  = poll_q;
    retry_d = retry_q;
    tail_d  = tail_q;
    r1_d    = r1_q;
    pend_d  = spi_req | (pend_q & ~spi_done);
    case (state_q)
      S_IDLE, S_DONE, S_FAIL:
        if (start) begin
          state_d = S_POWERUP;
          cnt_d   = '0;
          retry_d = '0;
          err_d   = E_NONE;
        end
      S_POWERUP:
        if (xfer) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == PU_LAST) begin
            state_d = S_SEND;
            cmd_d   = C_CMD0;
            cnt_d   = '0;
          end
        end
      S_SEND:
        if (xfer) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd5) begin
            state_d = S_WAIT;
            cnt_d   = '0;
            poll_d  = '0;
          end
        end
      S_WAIT:
        if (xfer) begin
          if (!spi_rx[7]) begin
            r1_d    = spi_rx;
            state_d = (cmd_q == C_CMD8 || cmd_q == C_CMD58) ? S_TAIL : S_CHECK;
          end else if (poll_q == NCR_LAST) begin
            err_d   = E_NCR;
            dst_d   = S_FAIL;
            state_d = S_DESEL;
          end else poll_d = poll_q + 4'd1;
        end
      S_TAIL:
        if (xfer) begin
          tail_d = {tail_q[23:0], spi_rx};
          cnt_d  = cnt_q + 4'd1;
          if (cnt_q == 4'd3) state_d = S_CHECK;
        end
      S_CHECK: begin
        state_d = S_DESEL;
        dst_d   = S_SEND;
        case (cmd_q)
          C_CMD0:
            if (r1_q == 8'h01) cmd_d = C_CMD8;
            else begin dst_d = S_FAIL; err_d = E_CMD0; end
          C_CMD8:
            if (r1_q == 8'h01 && tail_q[11:0] == 12'h1AA) cmd_d = C_CMD55;
            else begin dst_d = S_FAIL; err_d = E_CMD8; end
          C_CMD55:
            if (r1_q[7:1] == 7'd0) cmd_d = C_ACMD41;
            else begin dst_d = S_FAIL; err_d = E_CMD55; end
          C_ACMD41:
            if (r1_q == 8'h00) cmd_d = C_CMD58;
            else if (r1_q == 8'h01 && retry_q != RETRY_LAST) begin
              retry_d = retry_q + 16'd1;
              cmd_d   = C_CMD55;
            end else begin dst_d = S_FAIL; err_d = E_ACMD41; end
          default:
            if (r1_q == 8'h00) begin ccs_d = tail_q[30]; dst_d = S_DONE; end
            else begin dst_d = S_FAIL; err_d = E_CMD58; end
        endcase
      end
      S_DESEL:
        if (xfer) begin
          state_d = dst_q;
          cnt_d   = '0;
        end
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    xs       = state_q inside {S_POWERUP, S_SEND, S_WAIT, S_TAIL, S_DESEL};
    spi_req  = xs & ~pend_q;
    spi_tx   = state_q == S_SEND ? frame_tx : 8'hFF;
    sd_cs    = !(state_q inside {S_SEND, S_WAIT, S_TAIL, S_CHECK});
    busy     = !(state_q inside {S_IDLE, S_DONE, S_FAIL});
    init_ok  = state_q == S_DONE;
    init_err = state_q == S_FAIL;
    err_code = err_q;
    r1       = r1_q;
    ccs      = ccs_q;
  end
endmodule

// File: tb/tb_sd_init_ctrl.sv
// tb_sd_init_ctrl: byte-level SD card model plus expected wire-traffic scoreboard for sd_init_ctrl.
module tb_sd_init_ctrl;
  localparam int GAP = 2;
  logic clk = 1'b0, res, start, spi_req, spi_done, sd_cs, busy, init_ok, init_err, ccs;
  logic [7:0] spi_tx, spi_rx, r1;
  logic [2:0] err_code;
  int checks = 0, errors = 0, mode = 0, n41 = 0, nx = 0, nb = 0;
  logic [7:0] cq[$];
  logic [7:0] cbuf[6];
  logic [8:0] eq[$];
  logic [8:0] ee;
  always #5 clk = ~clk;
  sd_init_ctrl #(.POWERUP_BYTES(10), .NCR_MAX(8), .ACMD41_RETRIES(4)) dut (
    .clk(clk), .res(res), .start(start), .spi_req(spi_req), .spi_tx(spi_tx),
    .spi_done(spi_done), .spi_rx(spi_rx), .sd_cs(sd_cs), .busy(busy), .init_ok(init_ok),
    .init_err(init_err), .err_code(err_code), .r1(r1), .ccs(ccs)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask
  task automatic card_reset();
    cq.delete();
    nb = 0;
    n41 = 0;
  endtask
  task automatic push_r(input logic [7:0] b);
    repeat (GAP) cq.push_back(8'hFF);
    cq.push_back(b);
  endtask
  // card side of one byte exchange: mode 0 SDHC busy 3 tries, 1 mute, 2 bad CMD8 echo, 3 always busy
  task automatic card_xchg(input logic cs, input logic [7:0] tx, output logic [7:0] rx);
    if (cs) begin
      rx = 8'hFF;
      cq.delete();
      nb = 0;
    end else begin
      rx = cq.size() != 0 ? cq.pop_front() : 8'hFF;
      if (nb != 0 || tx != 8'hFF) begin
        cbuf[nb] = tx;
        nb++;
        if (nb == 6) begin
          nb = 0;
          if (mode != 1)
            case (cbuf[0][5:0])
              6'd0:  push_r(8'h01);
              6'd8:  begin
                push_r(8'h01);
                cq.push_back(8'h00); cq.push_back(8'h00); cq.push_back(8'h01);
                cq.push_back(mode == 2 ? 8'hAB : 8'hAA);
              end
              6'd55: push_r(8'h01);
              6'd41: begin n41++; push_r((mode == 3 || n41 <= 3) ? 8'h01 : 8'h00); end
              6'd58: begin
                push_r(8'h00);
                cq.push_back(8'hC0); cq.push_back(8'hFF); cq.push_back(8'h80); cq.push_back(8'h00);
              end
              default: ;
            endcase
        end
      end
    end
  endtask
  // expected wire traffic {cs, byte}: frame, Ncr polls, tail, deselect byte
  task automatic exp_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc,
                         input int polls, input int tail);
    logic [47:0] f;
    f = {2'b01, idx, arg, crc};
    for (int i = 0; i < 6; i++) eq.push_back({1'b0, f[47-8*i -: 8]});
    repeat (polls + tail) eq.push_back(9'h0FF);
    eq.push_back(9'h1FF);
  endtask
  task automatic build(input int m);
    eq.delete();
    repeat (10) eq.push_back(9'h1FF);
    if (m == 1) exp_cmd(6'd0, 32'h0, 8'h95, 8, 0);
    else begin
      exp_cmd(6'd0, 32'h0, 8'h95, GAP + 1, 0);
      exp_cmd(6'd8, 32'h1AA, 8'h87, GAP + 1, 4);
      if (m != 2) begin
        for (int i = 0; i < 4; i++) begin
          exp_cmd(6'd55, 32'h0, 8'hFF, GAP + 1, 0);
          exp_cmd(6'd41, 32'h4000_0000, 8'hFF, GAP + 1, 0);
        end
        if (m == 0) exp_cmd(6'd58, 32'h0, 8'hFF, GAP + 1, 4);
      end
    end
  endtask
  initial begin
    logic [7:0] rb, ctx;
    logic ccs_s;
    spi_done = 1'b0;
    spi_rx = 8'hFF;
    forever begin
      @(negedge clk);
      spi_done = 1'b0;
      spi_rx = 8'hFF;
      if (spi_req) begin
        ctx = spi_tx;
        ccs_s = sd_cs;
        card_xchg(sd_cs, spi_tx, rb);
        nx++;
        repeat (2) @(negedge clk);
        if (!res) chk("tx_stable", {ccs_s, ctx}, {sd_cs, spi_tx});
        spi_rx = rb;
        spi_done = 1'b1;
      end
    end
  end
  initial begin
    forever begin
      @(negedge clk);
      if (spi_req) begin
        if (eq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_req got cs=%b tx=%h want=none", sd_cs, spi_tx);
        end else begin
          ee = eq.pop_front();
          chk("wire_byte", {sd_cs, spi_tx}, ee);
        end
      end
      if (init_ok) chk("ok_err_excl", init_err, 1'b0);
    end
  end
  task automatic begin_run(input int m);
    mode = m;
    card_reset();
    nx = 0;
    build(m);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    chk("ok_cleared", init_ok, 1'b0);
    chk("err_cleared", init_err, 1'b0);
  endtask
  task automatic end_run(input logic ok, input logic [2:0] code, input logic [7:0] er1, input int en);
    for (int i = 0; i < 5000 && busy; i++) @(negedge clk);
    chk("done_in_time", busy, 1'b0);
    chk("init_ok", init_ok, ok);
    chk("init_err", init_err, !ok);
    chk("err_code", err_code, code);
    chk("r1", r1, er1);
    chk("cs_idle", sd_cs, 1'b1);
    chk("xchg_count", nx, en);
    chk("exp_left", eq.size(), 0);
    if (ok) chk("ccs", ccs, 1'b1);
  endtask
  initial begin
    res = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req", spi_req, 1'b0);
    chk("rst_tx", spi_tx, 8'hFF);
    chk("rst_cs", sd_cs, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_flags", {init_ok, init_err, err_code}, 5'd0);
    chk("rst_r1", r1, 8'hFF);
    chk("rst_ccs", ccs, 1'b0);
    res = 1'b0;
    begin_run(1);
    end_run(1'b0, 3'd6, 8'hFF, 25);
    begin_run(2);
    end_run(1'b0, 3'd2, 8'h01, 34);
    begin_run(3);
    end_run(1'b0, 3'd4, 8'h01, 114);
    chk("acmd41_tries_busy", n41, 4);
    begin_run(0);
    repeat (100) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    end_run(1'b1, 3'd0, 8'h00, 128);
    chk("acmd41_tries_sdhc", n41, 4);
    begin_run(0);
    end_run(1'b1, 3'd0, 8'h00, 128);
    begin_run(0);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (spi_req && spi_tx == 8'h48) break;
    end
    chk("cmd8_seen", {spi_req, spi_tx}, 9'h148);
    repeat (2) @(negedge clk);
    res = 1'b1;
    @(negedge clk);
    res = 1'b0;
    chk("abort_cs", sd_cs, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_req", spi_req, 1'b0);
    chk("abort_ok", init_ok, 1'b0);
    repeat (6) @(negedge clk);
    chk("abort_idle_req", spi_req, 1'b0);
    begin_run(0);
    end_run(1'b1, 3'd0, 8'h00, 128);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
